regfile_writeback_unit: RTL and testbench
=========================================

Name: regfile_writeback_unit

Overview:
- Write-side initiator for the 64-bit, 32-entry integer register file: drives its RegWrite/RD/WriteData port.
- Collects results from two pipeline producers, the ALU (EX/MEM) and the load path (MEM/WB).
- Queues results in a small in-order FIFO and retires at most one write per clock.
- Provides bypass data for rs1/rs2 whose writes are still queued or in flight, so decode never reads stale values.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- XLEN, 64, data width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- ld_valid  input  1  load result present.
- ld_rd  input  5  load destination register.
- ld_data  input  XLEN  load result.
- alu_valid  input  1  ALU result present.
- alu_rd  input  5  ALU destination register.
- alu_data  input  XLEN  ALU result.
- in_ready  output  1  producers may present results this cycle.
- RegWrite  output  1  register-file write enable (registered).
- RD  output  5  write address (registered).
- WriteData  output  XLEN  write data (registered).
- byp_rs1  input  5  bypass lookup address 1.
- byp_rs2  input  5  bypass lookup address 2.
- byp_hit1  output  1  pending write to byp_rs1 exists.
- byp_data1  output  XLEN  youngest pending value for byp_rs1.
- byp_hit2  output  1  pending write to byp_rs2 exists.
- byp_data2  output  XLEN  youngest pending value for byp_rs2.
- wr_count  output  32  committed-write counter (optional feature).
- stall_count  output  32  cycles with in_ready=0 (optional feature).

Behaviour:
- Reset values: RegWrite=0, RD=0, WriteData=0, FIFO empty (count=0, pointers 0), counters 0. in_ready=1 after reset.
- in_ready = (DEPTH - count) >= 2. It depends only on registered count, not on a same-cycle pop.
- A result is accepted when valid && in_ready. Results presented while in_ready=0 are ignored; producers must hold them.
- Enqueue order for a simultaneous ld and alu: ld first (older instruction), then alu. Both can be enqueued in the same cycle.
- rd==0 results are accepted but not stored. They do not change count and never produce a write.
- Drain: each cycle with count>0 (pre-enqueue), pop the head. Next edge: RegWrite=1, RD=head.rd, WriteData=head.data.
- Cycles with nothing to pop: RegWrite=0; RD and WriteData hold their values.
- Latency: a result enqueued into an empty FIFO appears on RegWrite at edge N+2 (edge N+1 enqueue, edge N+2 output).
- Push and pop in the same cycle: count = count + pushes - 1. Pointers wrap modulo DEPTH.
- Bypass (combinational) search order, youngest first:
  - FIFO entries, newest to oldest;
  - then the output register (RegWrite=1, RD match).
- byp_hitN=1 with the youngest matching data. No match, or byp_rsN==0: hit=0, data=0.
- Same-cycle incoming results are not bypassed.
- Asynchronous reset mid-operation discards all queued entries immediately; RegWrite falls without waiting for a clock.
- count never exceeds DEPTH, guaranteed by the in_ready rule. No overflow or underflow path exists.

Optional Feature:
- Macro: WB_PERF_CNT_EN.
- Defined: wr_count increments on every edge where RegWrite becomes or stays 1. stall_count increments on every cycle with in_ready=0. Both wrap at 2^32 and are cleared by reset.
- Undefined: both ports are tied to 0 and no counter flops are built.

Test Plan:
- Reset, then alu_valid=1, alu_rd=5, alu_data=0xAA for one cycle -> two edges later RegWrite=1, RD=5, WriteData=0xAA for exactly one cycle; wr_count=1 when the macro is defined.
- Same cycle ld_rd=3/0x11 and alu_rd=4/0x22 -> consecutive writes RD=3 then RD=4.
- Same cycle ld_rd=7/0x1 and alu_rd=7/0x2, byp_rs1=7 -> byp_hit1=1 and byp_data1=0x2 until the second write leaves RegWrite. Register-file writes land in order 0x1 then 0x2.
- alu_rd=0, alu_data=0xFF -> no RegWrite pulse; byp_rs1=0 gives hit=0.
- Push two results every cycle for 6 cycles with DEPTH=4 -> in_ready drops once count=3. No result is lost; writes drain one per cycle in order; stall_count equals the in_ready=0 cycles.
- Assert reset asynchronously while count=3 -> RegWrite=0 immediately, byp_hit1/2=0, in_ready=1. No stale writes appear after release.

Source files
------------

// File: rtl/regfile_writeback_unit.sv
// rtl/regfile_writeback_unit.sv - in-order writeback FIFO, register-file write port and rs1/rs2 bypass; optional counters under WB_PERF_CNT_EN
module regfile_writeback_unit #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ld_valid,
    input  logic [4:0]      ld_rd,
    input  logic [XLEN-1:0] ld_data,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            in_ready,
    output logic            RegWrite,
    output logic [4:0]      RD,
    output logic [XLEN-1:0] WriteData,
    input  logic [4:0]      byp_rs1,
    input  logic [4:0]      byp_rs2,
    output logic            byp_hit1,
    output logic [XLEN-1:0] byp_data1,
    output logic            byp_hit2,
    output logic [XLEN-1:0] byp_data2,
    output logic [31:0]     wr_count,
    output logic [31:0]     stall_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

    logic [4:0]      rd_mem_q   [DEPTH];
    logic [4:0]      rd_mem_d   [DEPTH];
    logic [XLEN-1:0] data_mem_q [DEPTH];
    logic [XLEN-1:0] data_mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            reg_write_q, reg_write_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] write_data_q, write_data_d;

    logic            push_ld;
    logic            push_alu;
    logic            pop;

    // Two free slots are needed because both producers may push at once;
    // a same-cycle pop is deliberately ignored to keep in_ready a flop-only path.
    assign in_ready = (count_q <= READY_MAX);
    assign push_ld  = ld_valid  && in_ready && (ld_rd  != 5'd0);
    assign push_alu = alu_valid && in_ready && (alu_rd != 5'd0);
    assign pop      = (count_q != '0);

    assign RegWrite  = reg_write_q;
    assign RD        = rd_q;
    assign WriteData = write_data_q;

    // FIFO next state: pop head into the output register, then enqueue ld before alu.
    always_comb begin
        rd_mem_d     = rd_mem_q;
        data_mem_d   = data_mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        reg_write_d  = 1'b0;
        rd_d         = rd_q;
        write_data_d = write_data_q;
        if (pop) begin
            reg_write_d  = 1'b1;
            rd_d         = rd_mem_q[rd_ptr_q];
            write_data_d = data_mem_q[rd_ptr_q];
            rd_ptr_d     = rd_ptr_q + PW'(1);
        end
        if (push_ld) begin
            rd_mem_d[wr_ptr_d]   = ld_rd;
            data_mem_d[wr_ptr_d] = ld_data;
            wr_ptr_d             = wr_ptr_d + PW'(1);
        end
        if (push_alu) begin
            rd_mem_d[wr_ptr_d]   = alu_rd;
            data_mem_d[wr_ptr_d] = alu_data;
            wr_ptr_d             = wr_ptr_d + PW'(1);
        end
        count_d = count_q + CW'(push_ld) + CW'(push_alu) - CW'(pop);
    end

    // State registers; reset drops RegWrite immediately and empties the queue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                rd_mem_q[i]   <= '0;
                data_mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            reg_write_q  <= 1'b0;
            rd_q         <= '0;
            write_data_q <= '0;
        end else begin
            rd_mem_q     <= rd_mem_d;
            data_mem_q   <= data_mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            reg_write_q  <= reg_write_d;
            rd_q         <= rd_d;
            write_data_q <= write_data_d;
        end
    end

    // Bypass lookup: output register first, then FIFO oldest to newest so the youngest match wins.
    always_comb begin
        logic [PW-1:0] slot;
        slot      = '0;
        byp_hit1  = 1'b0;
        byp_data1 = '0;
        byp_hit2  = 1'b0;
        byp_data2 = '0;
        if (reg_write_q && (rd_q == byp_rs1)) begin
            byp_hit1  = 1'b1;
            byp_data1 = write_data_q;
        end
        if (reg_write_q && (rd_q == byp_rs2)) begin
            byp_hit2  = 1'b1;
            byp_data2 = write_data_q;
        end
        for (int i = 0; i < DEPTH; i++) begin
            slot = rd_ptr_q + PW'(i);
            if (CW'(i) < count_q) begin
                if (rd_mem_q[slot] == byp_rs1) begin
                    byp_hit1  = 1'b1;
                    byp_data1 = data_mem_q[slot];
                end
                if (rd_mem_q[slot] == byp_rs2) begin
                    byp_hit2  = 1'b1;
                    byp_data2 = data_mem_q[slot];
                end
            end
        end
        if (byp_rs1 == 5'd0) begin
            byp_hit1  = 1'b0;
            byp_data1 = '0;
        end
        if (byp_rs2 == 5'd0) begin
            byp_hit2  = 1'b0;
            byp_data2 = '0;
        end
    end

`ifdef WB_PERF_CNT_EN
    logic [31:0] wr_count_q, wr_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    assign wr_count    = wr_count_q;
    assign stall_count = stall_count_q;

    // Count committed writes and back-pressure cycles; both wrap naturally.
    always_comb begin
        wr_count_d    = wr_count_q + 32'(reg_write_d);
        stall_count_d = stall_count_q + 32'(!in_ready);
    end

    // Counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_count_q    <= '0;
            stall_count_q <= '0;
        end else begin
            wr_count_q    <= wr_count_d;
            stall_count_q <= stall_count_d;
        end
    end
`else
    assign wr_count    = '0;
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_regfile_writeback_unit.sv
// tb/tb_regfile_writeback_unit.sv - scoreboard bench for regfile_writeback_unit
module tb_regfile_writeback_unit;

    localparam int DEPTH = 4;
    localparam int XLEN  = 64;

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wb_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            ld_valid = 1'b0;
    logic [4:0]      ld_rd = '0;
    logic [XLEN-1:0] ld_data = '0;
    logic            alu_valid = 1'b0;
    logic [4:0]      alu_rd = '0;
    logic [XLEN-1:0] alu_data = '0;
    logic            in_ready;
    logic            RegWrite;
    logic [4:0]      RD;
    logic [XLEN-1:0] WriteData;
    logic [4:0]      byp_rs1 = '0;
    logic [4:0]      byp_rs2 = '0;
    logic            byp_hit1;
    logic [XLEN-1:0] byp_data1;
    logic            byp_hit2;
    logic [XLEN-1:0] byp_data2;
    logic [31:0]     wr_count;
    logic [31:0]     stall_count;

    wb_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  tb_wr    = 0;
    int  tb_stall = 0;

    regfile_writeback_unit #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .reset(reset),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .in_ready(in_ready),
        .RegWrite(RegWrite), .RD(RD), .WriteData(WriteData),
        .byp_rs1(byp_rs1), .byp_rs2(byp_rs2),
        .byp_hit1(byp_hit1), .byp_data1(byp_data1),
        .byp_hit2(byp_hit2), .byp_data2(byp_data2),
        .wr_count(wr_count), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Write monitor: every register-file write must match the oldest expected result.
    always @(negedge clk) begin
        if (!reset && RegWrite) begin
            tb_wr++;
            if (exp_q.size() == 0) begin
                check_eq("unexpected_write", 64'(RD), 64'hdead);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                check_eq("wr_rd", 64'(RD), 64'(e.rd));
                check_eq("wr_data", WriteData, e.data);
            end
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) tb_stall = 0;
        else if (!in_ready) tb_stall++;
    end

    task automatic present(input logic lv, input logic [4:0] lrd, input logic [63:0] ldd,
                           input logic av, input logic [4:0] ard, input logic [63:0] add,
                           output logic acc);
        wb_t e;
        @(negedge clk);
        ld_valid = lv; ld_rd = lrd; ld_data = ldd;
        alu_valid = av; alu_rd = ard; alu_data = add;
        #1;
        acc = in_ready;
        if (lv && in_ready && lrd != 5'd0) begin
            e.rd = lrd; e.data = ldd; exp_q.push_back(e);
        end
        if (av && in_ready && ard != 5'd0) begin
            e.rd = ard; e.data = add; exp_q.push_back(e);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        ld_valid = 1'b0;
        alu_valid = 1'b0;
        #1;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        repeat (2) @(negedge clk);
        #1;
        check_eq("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic acc;
        int   k;
        int   c;
        logic [63:0] d0, d1;

        // Reset values
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("rst_regwrite", 64'(RegWrite), 64'd0);
        check_eq("rst_rd", 64'(RD), 64'd0);
        check_eq("rst_wdata", WriteData, 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_wr_count", 64'(wr_count), 64'd0);
        check_eq("rst_stall_count", 64'(stall_count), 64'd0);

        // Single ALU result: two-edge latency, one-cycle pulse
        present(1'b0, 5'd0, 64'd0, 1'b1, 5'd5, 64'hAA, acc);
        idle();
        check_eq("lat_n1_regwrite", 64'(RegWrite), 64'd0);
        @(negedge clk); #1;
        check_eq("lat_n2_regwrite", 64'(RegWrite), 64'd1);
        check_eq("lat_n2_rd", 64'(RD), 64'd5);
        check_eq("lat_n2_wdata", WriteData, 64'hAA);
        @(negedge clk); #1;
        check_eq("lat_n3_regwrite", 64'(RegWrite), 64'd0);
        check_eq("lat_n3_rd_hold", 64'(RD), 64'd5);
        check_eq("lat_n3_wdata_hold", WriteData, 64'hAA);
`ifdef WB_PERF_CNT_EN
        check_eq("wr_count_one", 64'(wr_count), 64'd1);
`endif

        // Simultaneous ld/alu to different registers: ld written first
        byp_rs2 = 5'd4;
        present(1'b1, 5'd3, 64'h11, 1'b1, 5'd4, 64'h22, acc);
        idle();
        check_eq("pair_byp_hit2", 64'(byp_hit2), 64'd1);
        check_eq("pair_byp_data2", byp_data2, 64'h22);
        drain();

        // Same destination from both producers: youngest (alu) value bypassed
        byp_rs1 = 5'd7;
        byp_rs2 = 5'd0;
        present(1'b1, 5'd7, 64'h1, 1'b1, 5'd7, 64'h2, acc);
        idle();
        check_eq("same_rd_t1_hit", 64'(byp_hit1), 64'd1);
        check_eq("same_rd_t1_data", byp_data1, 64'h2);
        @(negedge clk); #1;
        check_eq("same_rd_t2_hit", 64'(byp_hit1), 64'd1);
        check_eq("same_rd_t2_data", byp_data1, 64'h2);
        @(negedge clk); #1;
        check_eq("same_rd_t3_hit", 64'(byp_hit1), 64'd1);
        check_eq("same_rd_t3_data", byp_data1, 64'h2);
        @(negedge clk); #1;
        check_eq("same_rd_t4_hit", 64'(byp_hit1), 64'd0);
        check_eq("same_rd_t4_data", byp_data1, 64'h0);
        drain();

        // rd==0 result is dropped; rs==0 never hits
        byp_rs1 = 5'd0;
        present(1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 64'hFF, acc);
        idle();
        check_eq("x0_byp_hit", 64'(byp_hit1), 64'd0);
        check_eq("x0_in_ready", 64'(in_ready), 64'd1);
        repeat (2) begin
            @(negedge clk); #1;
            check_eq("x0_no_write", 64'(RegWrite), 64'd0);
        end

        // Burst of six pairs against a DEPTH=4 queue
        k = 0;
        c = 0;
        while (k < 6 && c < 40) begin
            d0 = {$urandom, $urandom};
            d1 = {$urandom, $urandom};
            present(1'b1, 5'(8 + 2 * k), d0, 1'b1, 5'(9 + 2 * k), d1, acc);
            check_eq("burst_in_ready", 64'(acc), 64'((c < 2) || (c % 2 == 1)));
            if (acc) k++;
            c++;
        end
        check_eq("burst_all_sent", 64'(k), 64'd6);
        idle();
        drain();
`ifdef WB_PERF_CNT_EN
        check_eq("stall_count", 64'(stall_count), 64'(tb_stall));
        check_eq("wr_count_total", 64'(wr_count), 64'(tb_wr));
`endif

        // Asynchronous reset with three entries queued
        present(1'b1, 5'd20, 64'h20, 1'b1, 5'd21, 64'h21, acc);
        present(1'b1, 5'd22, 64'h22, 1'b1, 5'd23, 64'h23, acc);
        check_eq("pre_rst_accept", 64'(acc), 64'd1);
        idle();
        byp_rs1 = 5'd23;
        byp_rs2 = 5'd21;
        #1;
        check_eq("pre_rst_in_ready", 64'(in_ready), 64'd0);
        check_eq("pre_rst_hit1", 64'(byp_hit1), 64'd1);
        check_eq("pre_rst_regwrite", 64'(RegWrite), 64'd1);
        #1;
        reset = 1'b1;
        #1;
        check_eq("arst_regwrite", 64'(RegWrite), 64'd0);
        check_eq("arst_hit1", 64'(byp_hit1), 64'd0);
        check_eq("arst_hit2", 64'(byp_hit2), 64'd0);
        check_eq("arst_in_ready", 64'(in_ready), 64'd1);
        check_eq("arst_wr_count", 64'(wr_count), 64'd0);
        exp_q.delete();
        tb_wr = 0;
        @(negedge clk);
        reset = 1'b0;
        repeat (5) begin
            @(negedge clk); #1;
            check_eq("post_rst_no_write", 64'(RegWrite), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
